// File: rtl/sksa_pkg.sv
// Shared definitions for the segmented Kogge-Stone adder checker:
// segment geometry, FSM state encoding and the per-segment mask type.
package sksa_pkg;
    localparam int NUM_SEG = 4;
    localparam int SEG_W   = 4;
    localparam int DATA_W  = NUM_SEG * SEG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [NUM_SEG-1:0] seg_mask_t;
endpackage

// File: rtl/sksa_fault_checker_seg_ref_adder.sv
// 4-bit reference ripple adder, time-shared across the segments of the
// operation under check.
module seg_ref_adder
    import sksa_pkg::*;
(
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    input  logic             i_cin,
    output logic [SEG_W-1:0] o_sum,
    output logic             o_cout
);
    logic [SEG_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG_W{1'b0}}, i_cin};
    assign o_sum  = w_full[SEG_W-1:0];
    assign o_cout = w_full[SEG_W];
endmodule

// File: rtl/sksa_fault_checker.sv
// Serial check-and-correct stage for the segmented adder: recomputes one
// segment per cycle, flags sum/carry mismatches and tracks permanent faults.
module sksa_fault_checker
    import sksa_pkg::*;
#(
    parameter int CONSEC_LIMIT = 3,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    input  logic [DATA_W-1:0] in_s,
    input  logic [NUM_SEG-1:0] in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_fault,
    output seg_mask_t         out_seg_fault,
    output seg_mask_t         out_carry_fault,
    output seg_mask_t         perm_fault,
    output logic [CNT_W-1:0]  fault_count
);
    state_t                    r_state, w_next;
    logic [DATA_W-1:0]         r_a, r_b, r_s, r_sum;
    logic [NUM_SEG-1:0]        r_carry;
    logic                      r_ref_c, r_cout, r_fault, r_out_valid;
    logic [1:0]                r_seg_idx;
    seg_mask_t                 r_seg_fault, r_carry_fault, r_perm;
    logic [CNT_W-1:0]          r_cnt;
    logic [NUM_SEG-1:0][2:0]   r_consec, w_consec_nxt;

    logic [SEG_W-1:0]          w_a_k, w_b_k, w_s_k, w_sum_k;
    logic                      w_cout_k, w_last, w_any;
    seg_mask_t                 w_seg_nxt, w_car_nxt, w_perm_nxt;

    assign w_a_k  = r_a[r_seg_idx*SEG_W +: SEG_W];
    assign w_b_k  = r_b[r_seg_idx*SEG_W +: SEG_W];
    assign w_s_k  = r_s[r_seg_idx*SEG_W +: SEG_W];
    assign w_last = (r_seg_idx == 2'(NUM_SEG-1));

    seg_ref_adder u_ref (
        .i_a    (w_a_k),
        .i_b    (w_b_k),
        .i_cin  (r_ref_c),
        .o_sum  (w_sum_k),
        .o_cout (w_cout_k)
    );

    // Masks as they will stand after this segment; used for the final bookkeeping.
    always_comb begin
        w_seg_nxt            = r_seg_fault;
        w_car_nxt            = r_carry_fault;
        w_seg_nxt[r_seg_idx] = (w_sum_k != w_s_k);
        w_car_nxt[r_seg_idx] = (w_cout_k != r_carry[r_seg_idx]);
        w_any                = |{w_seg_nxt, w_car_nxt};
        w_perm_nxt           = r_perm;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (w_seg_nxt[k] || w_car_nxt[k])
                w_consec_nxt[k] = (r_consec[k] == 3'd7) ? 3'd7 : r_consec[k] + 3'd1;
            else
                w_consec_nxt[k] = 3'd0;
            if (w_consec_nxt[k] >= 3'(CONSEC_LIMIT))
                w_perm_nxt[k] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = CHECK;
            CHECK:   if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_s           <= '0;
            r_carry       <= '0;
            r_ref_c       <= 1'b0;
            r_seg_idx     <= '0;
            r_sum         <= '0;
            r_cout        <= 1'b0;
            r_fault       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_seg_fault   <= '0;
            r_carry_fault <= '0;
            r_perm        <= '0;
            r_cnt         <= '0;
            r_consec      <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a       <= in_a;
                    r_b       <= in_b;
                    r_s       <= in_s;
                    r_carry   <= in_carry;
                    r_ref_c   <= in_cin;
                    r_seg_idx <= '0;
                end
                CHECK: begin
                    r_sum[r_seg_idx*SEG_W +: SEG_W] <= w_sum_k;
                    r_seg_fault   <= w_seg_nxt;
                    r_carry_fault <= w_car_nxt;
                    // Chain the reference carry, never the checked adder's carry.
                    r_ref_c       <= w_cout_k;
                    r_seg_idx     <= r_seg_idx + 2'd1;
                    if (w_last) begin
                        r_cout      <= w_cout_k;
                        r_fault     <= w_any;
                        r_out_valid <= 1'b1;
                        r_consec    <= w_consec_nxt;
                        r_perm      <= w_perm_nxt;
                        if (w_any && (r_cnt != '1))
                            r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready        = (r_state == IDLE) && !rst;
    assign out_valid       = r_out_valid;
    assign out_sum         = r_sum;
    assign out_cout        = r_cout;
    assign out_fault       = r_fault;
    assign out_seg_fault   = r_seg_fault;
    assign out_carry_fault = r_carry_fault;
    assign perm_fault      = r_perm;
    assign fault_count     = r_cnt;
endmodule

// File: doc/sksa_fault_checker.md
# sksa_fault_checker

Sequential check-and-correct stage directly downstream of the 16-bit segmented Kogge-Stone adder (`sksa`). It captures the adder's operands, sum and segment carries (`carry4`, `carry8`, `carry12`, `cout`) through a valid/ready handshake. It then recomputes each 4-bit segment serially with a single reference adder and flags sum and carry mismatches per segment. It returns the corrected result and tracks transient versus permanent segment faults.

## Interface
- `CONSEC_LIMIT`, default 3: consecutive faulty checks of one segment that declare that segment permanently faulty (range 1..7).
- `CNT_W`, default 8: width of the saturating faulty-operation counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: capture request.
- `in_ready` out 1: high only in IDLE and not in reset.
- `in_a`, `in_b` in 16: adder operands.
- `in_cin` in 1: adder carry-in.
- `in_s` in 16: sum produced by the adder under check.
- `in_carry` in 4: {cout, carry12, carry8, carry4} from the adder under check.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accept.
- `out_sum` out 16: corrected (reference) sum.
- `out_cout` out 1: corrected carry-out.
- `out_fault` out 1: OR of all mismatch bits for this operation.
- `out_seg_fault` out 4: bit k set when `in_s[4k+3:4k]` differs from the reference segment sum.
- `out_carry_fault` out 4: bit k set when `in_carry[k]` differs from the reference carry-out of segment k.
- `perm_fault` out 4: sticky per-segment permanent-fault flags.
- `fault_count` out CNT_W: saturating count of operations with `out_fault`=1.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, register all inputs, clear `seg_idx` to 0, set `ref_c` = `in_cin`, and go to CHECK.
  - CHECK: one segment per cycle, k = `seg_idx` from 0 to 3.
    - Reference: {c_out, sum4} = a_k + b_k + `ref_c`, computed as a 5-bit zero-extended sum.
    - Write sum4 into `out_sum[4k+3:4k]`.
    - Set `out_seg_fault[k]` = (sum4 != s_k) and `out_carry_fault[k]` = (c_out != carry_k).
    - Propagate the reference carry: `ref_c` <= c_out. The carry from the adder under check is never used.
    - After k=3, set `out_cout` to the segment-3 c_out and go to DONE.
  - DONE: `out_valid`=1. Outputs stay stable until `out_valid && out_ready`, then go to IDLE.
- Bookkeeping on the CHECK->DONE transition:
  - Per-segment consecutive counter (3 bits): increment, saturating, if the segment has a sum or carry fault; otherwise clear it.
  - Set `perm_fault[k]` when its counter reaches `CONSEC_LIMIT`. The flag stays set until `rst`.
  - `fault_count` += 1 if `out_fault`, saturating at all-ones.
- Inputs are ignored outside IDLE. No capture occurs while busy, so an overlapping `in_valid` is simply held off.
- `perm_fault` is reported only; the corrected sum is always the reference value.

## Timing
- Handshake on cycle T (`in_valid && in_ready` at edge T).
- CHECK covers edges T+1 to T+4; `out_valid` rises after edge T+4.
- Accept-to-result latency: 4 cycles. Minimum issue interval: 6 cycles, since `in_ready` returns the cycle after the output handshake.
- `out_*` results are registered and glitch-free while `out_valid`=1.
- `out_valid` stays 0 in IDLE and CHECK.
- Reset values, the cycle after `rst` sampled high:
  - State IDLE; `in_ready`=1 once `rst` is low.
  - `out_valid`=0; `out_sum`=0; `out_cout`=0; `out_fault`=0.
  - All fault masks 0; `perm_fault`=0; `fault_count`=0; consecutive counters 0.
- Reset mid-CHECK or mid-DONE aborts the operation. No partial result is ever presented, and counters are not updated.

## Structure
- `sksa_pkg` holds:
  - `NUM_SEG`=4 and `SEG_W`=4.
  - The FSM state enum {IDLE, CHECK, DONE}.
  - A typedef for the per-segment 4-bit mask.
- One sub-module, `seg_ref_adder`: 4-bit a, b, cin -> 4-bit sum, cout. It is combinational, instantiated once and time-shared across segments.

## Test plan
- a=0x1234, b=0x4321, cin=0, s=0x5555, carry=0000 -> `out_sum`=0x5555, `out_fault`=0, `out_valid` 4 cycles after accept.
- a=0x0F0F, b=0x0101, cin=1, s=0x1E11, carry=0101 -> `out_sum`=0x1011, `out_cout`=0, `out_seg_fault`=0100, `out_carry_fault`=0000, `fault_count`=1.
- a=0xFFFF, b=0x0001, cin=0, s=0x0000, carry=1011 -> `out_sum`=0x0000, `out_cout`=1, `out_carry_fault`=0100, `out_seg_fault`=0000.
- Hold `out_ready`=0 for 3 cycles in DONE while `in_valid`=1 with new data -> outputs stable, `in_ready`=0, no capture; accept on the 4th cycle, then `in_ready`=1 on the next cycle.
- Three consecutive operations with a segment-2 sum fault -> `perm_fault`=0100 when the third `out_valid` rises.
  - Fault, clean, fault, fault -> `perm_fault` stays 0000.
- `rst` asserted on the 2nd CHECK cycle -> next cycle `out_valid`=0 and `in_ready`=1; counters unchanged from 0; next clean operation gives `out_fault`=0.
